// File: rtl/epw_proc_core.sv
// EPW processing core: stage1 -> result reg -> dly-stage delay line -> output reg (2+dly cycles).
// Backpressure: in_ready is low only while draining for store_dly/reset_op; otherwise 1 command/cycle.
module epw_proc_core #(
   parameter int DATA_W   = 16,
   parameter int NUM_KEYS = 8,
   parameter int XLAT_DW  = 8,
   parameter int TAG_W    = 2,
   parameter int MAX_DLY  = 7
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [3:0]                  in_op,
   input  logic [$clog2(NUM_KEYS)-1:0] in_key_sel,
   input  logic [DATA_W-1:0]           in_data,
   input  logic [TAG_W-1:0]            in_tag,
   output logic                        out_valid,
   output logic [DATA_W-1:0]           out_result,
   output logic [TAG_W-1:0]            out_tag,
   output logic                        err
);
   localparam int KS_W  = $clog2(NUM_KEYS);
   localparam int DLY_W = $clog2(MAX_DLY + 1);
   localparam int NSL   = DATA_W / XLAT_DW;
   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;
   localparam logic [DATA_W-1:0] DW_L     = DATA_W'(DATA_W);
   localparam logic [3:0]        MAX_DLY4 = 4'(MAX_DLY);

   logic [0:0]          state;
   logic [DATA_W-1:0]   keys [NUM_KEYS];
   logic [XLAT_DW-1:0]  xlat [2**XLAT_DW];
   logic [DLY_W-1:0]    dly;
   logic                pend_clr;
   logic [3:0]          pend_dat;

   logic                s1_vld;
   logic [3:0]          s1_op;
   logic [KS_W-1:0]     s1_sel;
   logic [DATA_W-1:0]   s1_dat;
   logic [TAG_W-1:0]    s1_tag;

   logic                res_vld;
   logic [DATA_W-1:0]   res_dat;
   logic [TAG_W-1:0]    res_tag;

   logic [MAX_DLY-1:0]  dl_vld;
   logic [DATA_W-1:0]   dl_dat [MAX_DLY];
   logic [TAG_W-1:0]    dl_tag [MAX_DLY];

   logic                accept;
   logic                drain_done;
   logic [DATA_W-1:0]   key_k;
   logic [DATA_W-1:0]   amt;
   logic [2*DATA_W-1:0] rot_l2;
   logic [2*DATA_W-1:0] rot_r2;
   logic [DATA_W-1:0]   tbl_res;
   logic [DATA_W-1:0]   exe_res;
   logic                s1_rsvd;

   assign in_ready   = (state == ST_RUN);
   assign accept     = in_valid & in_ready;
   assign key_k      = keys[s1_sel];
   assign amt        = key_k % DW_L;
   assign s1_rsvd    = s1_vld && (s1_op >= 4'h5) && (s1_op <= 4'h7);
   // Delay stages beyond dly never hold valid entries, so the whole vector reflects occupancy.
   assign drain_done = (state == ST_DRAIN) && !s1_vld && !res_vld && (dl_vld == '0);

   always_comb begin
      rot_l2  = {s1_dat, s1_dat} << amt;
      rot_r2  = {s1_dat, s1_dat} >> amt;
      tbl_res = '0;
      for (int i = 0; i < NSL; i++)
         tbl_res[i*XLAT_DW +: XLAT_DW] = xlat[s1_dat[i*XLAT_DW +: XLAT_DW]];
      case (s1_op[1:0])
         2'b00:   exe_res = rot_l2[2*DATA_W-1:DATA_W];
         2'b01:   exe_res = rot_r2[DATA_W-1:0];
         2'b10:   exe_res = s1_dat ^ key_k;
         default: exe_res = tbl_res;
      endcase
   end

   always_ff @(posedge clk) begin
      if (s1_vld && s1_op == 4'h4)
         xlat[s1_dat[2*XLAT_DW-1:XLAT_DW]] <= s1_dat[XLAT_DW-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_RUN;
         dly      <= '0;
         pend_clr <= 1'b0;
         pend_dat <= '0;
         for (int i = 0; i < NUM_KEYS; i++) keys[i] <= '0;
         s1_vld   <= 1'b0;
         s1_op    <= '0;
         s1_sel   <= '0;
         s1_dat   <= '0;
         s1_tag   <= '0;
         err      <= 1'b0;
      end else begin
         s1_vld <= accept;
         if (accept) begin
            s1_op  <= in_op;
            s1_sel <= in_key_sel;
            s1_dat <= in_data;
            s1_tag <= in_tag;
         end
         err <= s1_rsvd || (drain_done && !pend_clr && (pend_dat > MAX_DLY4));
         if (state == ST_RUN) begin
            if (accept && (in_op == 4'h1 || in_op == 4'h2)) begin
               state    <= ST_DRAIN;
               pend_clr <= (in_op == 4'h1);
               pend_dat <= in_data[3:0];
            end
         end else if (drain_done) begin
            state <= ST_RUN;
            if (pend_clr) begin
               dly <= '0;
               for (int i = 0; i < NUM_KEYS; i++) keys[i] <= '0;
            end else begin
               dly <= (pend_dat > MAX_DLY4) ? DLY_W'(MAX_DLY) : DLY_W'(pend_dat);
            end
         end
         if (s1_vld && s1_op == 4'h3)
            keys[s1_sel] <= s1_dat;
         else if (s1_vld && s1_op[3:2] == 2'b11)
            keys[s1_sel] <= exe_res;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res_vld    <= 1'b0;
         res_dat    <= '0;
         res_tag    <= '0;
         dl_vld     <= '0;
         for (int i = 0; i < MAX_DLY; i++) begin
            dl_dat[i] <= '0;
            dl_tag[i] <= '0;
         end
         out_valid  <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
      end else begin
         res_vld <= s1_vld && s1_op[3];
         res_dat <= exe_res;
         res_tag <= s1_tag;
         dl_vld[0] <= res_vld && (dly != '0);
         dl_dat[0] <= res_dat;
         dl_tag[0] <= res_tag;
         for (int i = 1; i < MAX_DLY; i++) begin
            dl_vld[i] <= dl_vld[i-1] && (DLY_W'(i) < dly);
            dl_dat[i] <= dl_dat[i-1];
            dl_tag[i] <= dl_tag[i-1];
         end
         if (dly == '0) begin
            out_valid <= res_vld;
            if (res_vld) begin
               out_result <= res_dat;
               out_tag    <= res_tag;
            end
         end else begin
            out_valid <= dl_vld[dly - 1'b1];
            if (dl_vld[dly - 1'b1]) begin
               out_result <= dl_dat[dly - 1'b1];
               out_tag    <= dl_tag[dly - 1'b1];
            end
         end
      end
   end
endmodule

// File: tb/tb_epw_proc_core.sv
// Self-checking bench for epw_proc_core: vector table streamed through a result scoreboard,
// plus hand sequences for drain, saturation, reserved ops and resets.
module tb_epw_proc_core;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_op = '0;
   logic [2:0]  in_key_sel = '0;
   logic [15:0] in_data = '0;
   logic [1:0]  in_tag = '0;
   logic        out_valid;
   logic [15:0] out_result;
   logic [1:0]  out_tag;
   logic        err;

   epw_proc_core dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_key_sel(in_key_sel), .in_data(in_data), .in_tag(in_tag),
      .out_valid(out_valid), .out_result(out_result), .out_tag(out_tag), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] res;
      logic [1:0]  tag;
      int          due;
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      logic [2:0]  sel;
      logic [15:0] dat;
      logic [1:0]  tag;
      logic        has_res;
      logic [15:0] exp;
   } vec_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   mdly = 0;
   int   err_cnt = 0;
   int   last_err_cyc = -1;
   int   last_out_cyc = -1;
   int   last_send_cyc = 0;
   int   out_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset_n) begin
         if (out_valid) begin
            out_seen++;
            checks++;
            if (sbq.size() == 0) begin
               failures++;
               $display("FAIL unexpected_out: result=%h tag=%0d at cyc %0d, none expected", out_result, out_tag, cyc);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               if (out_result !== e.res || out_tag !== e.tag || cyc != e.due) begin
                  failures++;
                  $display("FAIL result: got %h tag %0d cyc %0d, want %h tag %0d cyc %0d",
                           out_result, out_tag, cyc, e.res, e.tag, e.due);
               end
            end
            last_out_cyc = cyc;
         end
         if (err) begin
            err_cnt++;
            last_err_cyc = cyc;
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s: got %0d (0x%h), want %0d (0x%h)", name, got, got, want, want);
      end
   endtask

   task automatic send(input logic [3:0] op, input logic [2:0] sel, input logic [15:0] d,
                       input logic [1:0] tag, input logic has_res, input logic [15:0] exp);
      int t;
      exp_t e;
      @(negedge clk);
      t = 0;
      while (!in_ready && t < 60) begin
         in_valid = 1'b0;
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready=0 after %0d cycles, want 1", t);
      end else begin
         in_valid = 1'b1; in_op = op; in_key_sel = sel; in_data = d; in_tag = tag;
         last_send_cyc = cyc;
         if (has_res) begin
            e.res = exp; e.tag = tag; e.due = cyc + 3 + mdly;
            sbq.push_back(e);
         end
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 60) begin
         @(negedge clk);
         t++;
      end
      check("wait_ready", int'(in_ready), 1);
   endtask

   task automatic wait_empty();
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      check("scoreboard_drained", sbq.size(), 0);
   endtask

   vec_t vecs[17];
   int   e0;
   int   rdy_cyc;
   int   t;

   initial begin
      vecs[0]  = '{4'h3, 3'd2, 16'h00FF, 2'd0, 1'b0, 16'h0000};
      vecs[1]  = '{4'hA, 3'd2, 16'h0F0F, 2'd1, 1'b1, 16'h0FF0};
      vecs[2]  = '{4'h3, 3'd0, 16'h0013, 2'd0, 1'b0, 16'h0000};
      vecs[3]  = '{4'h8, 3'd0, 16'h8001, 2'd2, 1'b1, 16'h000C};
      vecs[4]  = '{4'h9, 3'd0, 16'h8001, 2'd3, 1'b1, 16'h3000};
      vecs[5]  = '{4'h4, 3'd0, 16'h12AB, 2'd0, 1'b0, 16'h0000};
      vecs[6]  = '{4'h4, 3'd0, 16'h3455, 2'd0, 1'b0, 16'h0000};
      vecs[7]  = '{4'hB, 3'd0, 16'h3412, 2'd0, 1'b1, 16'h55AB};
      vecs[8]  = '{4'hF, 3'd5, 16'h3412, 2'd1, 1'b1, 16'h55AB};
      vecs[9]  = '{4'hA, 3'd5, 16'h0000, 2'd2, 1'b1, 16'h55AB};
      vecs[10] = '{4'h3, 3'd1, 16'h0020, 2'd0, 1'b0, 16'h0000};
      vecs[11] = '{4'h8, 3'd1, 16'h1234, 2'd3, 1'b1, 16'h1234};
      vecs[12] = '{4'hC, 3'd0, 16'h8001, 2'd1, 1'b1, 16'h000C};
      vecs[13] = '{4'hA, 3'd0, 16'hFFFF, 2'd0, 1'b1, 16'hFFF3};
      vecs[14] = '{4'h0, 3'd0, 16'hFFFF, 2'd0, 1'b0, 16'h0000};
      vecs[15] = '{4'hE, 3'd2, 16'hF0F0, 2'd2, 1'b1, 16'hF00F};
      vecs[16] = '{4'hD, 3'd2, 16'h0001, 2'd3, 1'b1, 16'h0002};

      // reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_result", int'(out_result), 0);
      check("rst_out_tag", int'(out_tag), 0);
      check("rst_err", int'(err), 0);
      reset_n = 1'b1;

      for (int i = 0; i < 17; i++)
         send(vecs[i].op, vecs[i].sel, vecs[i].dat, vecs[i].tag, vecs[i].has_res, vecs[i].exp);
      send(4'hA, 3'd2, 16'h0000, 2'd1, 1'b1, 16'h0002);
      wait_empty();

      // drain: three streamed results, then store_dly 3
      send(4'hA, 3'd2, 16'h0010, 2'd0, 1'b1, 16'h0012);
      send(4'hA, 3'd2, 16'h0020, 2'd1, 1'b1, 16'h0022);
      send(4'hA, 3'd2, 16'h0030, 2'd2, 1'b1, 16'h0032);
      send(4'h2, 3'd0, 16'h0003, 2'd0, 1'b0, 16'h0000);
      mdly = 3;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      rdy_cyc = cyc;
      check("drain_ready_after_last_out", last_out_cyc, rdy_cyc - 1);
      check("drain_queue_empty", sbq.size(), 0);
      send(4'hA, 3'd2, 16'h0100, 2'd3, 1'b1, 16'h0102);
      wait_empty();

      // saturated delay
      e0 = err_cnt;
      send(4'h2, 3'd0, 16'h000F, 2'd0, 1'b0, 16'h0000);
      mdly = 7;
      wait_ready();
      repeat (2) @(negedge clk);
      check("sat_err_pulses", err_cnt, e0 + 1);
      send(4'hA, 3'd2, 16'h0000, 2'd1, 1'b1, 16'h0002);
      wait_empty();

      // reserved opcode
      e0 = err_cnt;
      send(4'h6, 3'd0, 16'h1234, 2'd0, 1'b0, 16'h0000);
      repeat (4) @(negedge clk);
      check("rsvd_err_pulses", err_cnt, e0 + 1);
      check("rsvd_err_cycle", last_err_cyc, last_send_cyc + 2);

      // reset_op mid-stream
      send(4'hA, 3'd2, 16'h1000, 2'd0, 1'b1, 16'h1002);
      send(4'hA, 3'd2, 16'h2000, 2'd1, 1'b1, 16'h2002);
      send(4'h1, 3'd0, 16'h0000, 2'd0, 1'b0, 16'h0000);
      mdly = 0;
      send(4'hA, 3'd3, 16'hA5A5, 2'd1, 1'b1, 16'hA5A5);
      send(4'hA, 3'd2, 16'h0001, 2'd2, 1'b1, 16'h0001);
      wait_empty();

      // async reset with results in flight
      send(4'hA, 3'd0, 16'h1111, 2'd0, 1'b1, 16'h1111);
      send(4'hA, 3'd0, 16'h2222, 2'd1, 1'b1, 16'h2222);
      #2 reset_n = 1'b0;
      sbq.delete();
      out_seen = 0;
      #4 reset_n = 1'b1;
      repeat (15) @(negedge clk);
      check("no_out_after_async_reset", out_seen, 0);
      check("ready_after_async_reset", int'(in_ready), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
